// File: rtl/knight_rider_ctrl.sv
// Command sequencer for the Knight Rider scanner: valid/ready mode commands in, prescaled step strobe out.
// Optional PARK state (STOP returns the scanner to home first) is enabled by defining KR_CTRL_PARK_EN.
module knight_rider_ctrl #(
  parameter int unsigned BASE_DIV = 4,
  parameter int unsigned PRESC_W  = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [1:0] cmd_op,
  input  logic [1:0] cmd_speed,
  input  logic [2:0] pos,
  input  logic       dir,
  output logic       step,
  output logic       done,
  output logic       busy,
  output logic [2:0] state
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_RUN   = 3'd1;
  localparam logic [2:0] S_SWEEP = 3'd2;
  localparam logic [2:0] S_PAUSE = 3'd3;
`ifdef KR_CTRL_PARK_EN
  localparam logic [2:0] S_PARK  = 3'd4;
  localparam logic [2:0] S_STOP  = S_PARK;
`else
  localparam logic [2:0] S_STOP  = S_IDLE;
`endif

  localparam logic [1:0] OP_STOP  = 2'd0;
  localparam logic [1:0] OP_RUN   = 2'd1;
  localparam logic [1:0] OP_SWEEP = 2'd2;
  localparam logic [1:0] OP_PAUSE = 2'd3;

  // One round trip over 8 positions is 14 steps; counter holds 0..13 during step cycles.
  localparam logic [3:0] SWEEP_LAST = 4'd13;

  logic [2:0]         ret_state;
  logic [2:0]         nxt_state;
  logic [2:0]         nxt_ret;
  logic [1:0]         speed;
  logic [3:0]         sweep_cnt;
  logic [PRESC_W-1:0] presc;
  logic [PRESC_W-1:0] period_m1;
  logic               accept;
  logic               restart;
  logic               clr_sweep;
  logic               stop_acc;
  logic               sweep_end;
  logic               running;
  logic               nxt_running;
  logic               wrap;

  function automatic logic is_running(input logic [2:0] s);
`ifdef KR_CTRL_PARK_EN
    return (s == S_RUN) || (s == S_SWEEP) || (s == S_PARK);
`else
    return (s == S_RUN) || (s == S_SWEEP);
`endif
  endfunction

`ifdef KR_CTRL_PARK_EN
  assign cmd_ready = (state != S_PARK) && !step;
`else
  logic unused_home;
  assign cmd_ready   = !step;
  assign unused_home = ^{pos, dir};
`endif

  assign accept      = cmd_valid && cmd_ready;
  assign busy        = (state != S_IDLE);
  assign period_m1   = PRESC_W'((BASE_DIV << speed) - 1);
  assign wrap        = (presc == period_m1);
  assign running     = is_running(state);
  assign nxt_running = is_running(nxt_state);

  always_comb begin
    nxt_state = state;
    nxt_ret   = ret_state;
    restart   = 1'b0;
    clr_sweep = 1'b0;
    stop_acc  = 1'b0;
    sweep_end = 1'b0;
    if (accept) begin
      case (cmd_op)
        OP_RUN: begin
          nxt_state = S_RUN;
          restart   = 1'b1;
        end
        OP_SWEEP: begin
          nxt_state = S_SWEEP;
          restart   = 1'b1;
          clr_sweep = 1'b1;
        end
        OP_PAUSE: begin
          if (state == S_RUN || state == S_SWEEP) begin
            nxt_state = S_PAUSE;
            nxt_ret   = state;
          end else if (state == S_PAUSE) begin
            nxt_state = ret_state;
          end
        end
        OP_STOP: begin
          if (state != S_IDLE) begin
            nxt_state = S_STOP;
            stop_acc  = 1'b1;
          end
        end
      endcase
    end else if (state == S_SWEEP && step && sweep_cnt == SWEEP_LAST) begin
      nxt_state = S_IDLE;
      sweep_end = 1'b1;
    end
`ifdef KR_CTRL_PARK_EN
    else if (state == S_PARK && !step && pos == 3'd0 && !dir) begin
      nxt_state = S_IDLE;
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= S_IDLE;
      ret_state <= S_RUN;
      speed     <= '0;
      presc     <= '0;
      sweep_cnt <= '0;
      step      <= 1'b0;
      done      <= 1'b0;
    end else begin
      state     <= nxt_state;
      ret_state <= nxt_ret;
      done      <= sweep_end;
      step      <= 1'b0;
      if (restart) speed <= cmd_speed;
      if (restart || stop_acc || nxt_state == S_IDLE) begin
        presc <= '0;
      end else if (running) begin
        // A wrap that coincides with entering PAUSE holds at terminal count,
        // so the step fires on the first edge after resume and phase is kept.
        if (!wrap) begin
          presc <= presc + 1'b1;
        end else if (nxt_running) begin
          presc <= '0;
          step  <= 1'b1;
        end
      end
      if (clr_sweep || sweep_end) begin
        sweep_cnt <= '0;
      end else if (state == S_SWEEP && step) begin
        sweep_cnt <= sweep_cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_knight_rider_ctrl.sv
// Bench for knight_rider_ctrl: directed vector table, multi-cycle corner sequences,
// then a randomized run compared against a countdown-based reference model.
module tb_knight_rider_ctrl;

  localparam int BD = 4;
`ifdef KR_CTRL_PARK_EN
  localparam bit PARK = 1'b1;
`else
  localparam bit PARK = 1'b0;
`endif

  logic       clk;
  logic       reset;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [1:0] cmd_op;
  logic [1:0] cmd_speed;
  logic [2:0] pos;
  logic       dir;
  logic       step;
  logic       done;
  logic       busy;
  logic [2:0] state;

  logic       ld_req;
  logic [2:0] ld_pos;
  logic       ld_dir;

  int n_total = 0;
  int n_pass  = 0;

  knight_rider_ctrl #(.BASE_DIV(BD), .PRESC_W(16)) dut (
    .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_speed(cmd_speed), .pos(pos), .dir(dir),
    .step(step), .done(done), .busy(busy), .state(state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Scan counter/direction datapath: bounces between 0 and 7, moving on each step.
  always @(posedge clk) begin
    if (reset) begin
      pos <= 3'd0;
      dir <= 1'b0;
    end else if (ld_req) begin
      pos <= ld_pos;
      dir <= ld_dir;
    end else if (step) begin
      if (!dir) begin
        pos <= pos + 3'd1;
        if (pos == 3'd6) dir <= 1'b1;
      end else begin
        pos <= pos - 3'd1;
        if (pos == 3'd1) dir <= 1'b0;
      end
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset     = 1'b1;
    cmd_valid = 1'b0;
    tick();
    reset = 1'b0;
  endtask

  // Present a command and return #1 after the edge that accepts it.
  task automatic send(input logic [1:0] op, input logic [1:0] sp);
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_speed = sp;
    for (int i = 0; i < 400 && !cmd_ready; i++) tick();
    chk("send_ready", cmd_ready, 1);
    tick();
    cmd_valid = 1'b0;
  endtask

  task automatic count_to_step(input int budget, output int lat);
    lat = 0;
    for (int k = 1; k <= budget; k++) begin
      tick();
      if (step) begin
        lat = k;
        break;
      end
    end
  endtask

  // Reference model: cycles-left-until-step countdown, mode, saved mode, steps taken in sweep.
  int m_mode, m_saved, m_speed, m_left, m_sweeps;
  bit m_step, m_done;

  function automatic int period(input int sp);
    return BD << sp;
  endfunction

  function automatic bit m_ready();
    return (m_mode != 4) && !m_step;
  endfunction

  function automatic logic [6:0] m_vec();
    logic [2:0] ms;
    ms = m_mode[2:0];
    return {ms, (m_mode != 0), m_step, m_done, m_ready()};
  endfunction

  task automatic model_edge();
    bit acc, prev_step, run;
    prev_step = m_step;
    acc       = cmd_valid && m_ready();
    run       = (m_mode == 1) || (m_mode == 2) || (m_mode == 4);
    m_step    = 0;
    m_done    = 0;
    if (reset) begin
      m_mode = 0; m_saved = 1; m_speed = 0; m_left = 0; m_sweeps = 0;
    end else if (acc && cmd_op == 2'd1) begin
      m_mode = 1; m_speed = cmd_speed; m_left = period(m_speed);
    end else if (acc && cmd_op == 2'd2) begin
      m_mode = 2; m_speed = cmd_speed; m_left = period(m_speed); m_sweeps = 0;
    end else if (acc && cmd_op == 2'd3 && (m_mode == 1 || m_mode == 2)) begin
      m_saved = m_mode; m_mode = 3;
      if (m_left > 1) m_left--;
    end else if (acc && cmd_op == 2'd3 && m_mode == 3) begin
      m_mode = m_saved;
    end else if (acc && cmd_op == 2'd0 && m_mode != 0) begin
      m_mode = PARK ? 4 : 0; m_left = period(m_speed);
    end else if (m_mode == 2 && prev_step && m_sweeps == 14) begin
      m_mode = 0; m_done = 1;
    end else if (PARK && m_mode == 4 && !prev_step && pos == 3'd0 && !dir) begin
      m_mode = 0;
    end else if (run) begin
      m_left--;
      if (m_left == 0) begin
        m_step = 1;
        m_left = period(m_speed);
        if (m_mode == 2) m_sweeps++;
      end
    end
  endtask

  typedef struct {
    logic [1:0] op;
    logic [1:0] speed;
    int         exp_state;
    int         exp_lat;   // 0: no step expected
  } vec_t;

  vec_t vecs [0:7];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int lat, n, last, bad, dones, done_at, st_done;

    vecs[0] = '{2'd1, 2'd0, 1, 4};
    vecs[1] = '{2'd1, 2'd1, 1, 8};
    vecs[2] = '{2'd1, 2'd2, 1, 16};
    vecs[3] = '{2'd1, 2'd3, 1, 32};
    vecs[4] = '{2'd2, 2'd0, 2, 4};
    vecs[5] = '{2'd2, 2'd3, 2, 32};
    vecs[6] = '{2'd3, 2'd2, 0, 0};
    vecs[7] = '{2'd0, 2'd1, 0, 0};

    reset = 1'b1; cmd_valid = 1'b0; cmd_op = 2'd0; cmd_speed = 2'd0;
    ld_req = 1'b0; ld_pos = 3'd0; ld_dir = 1'b0;

    // Reset values
    do_reset();
    chk("rst_state", state, 0);
    chk("rst_step", step, 0);
    chk("rst_done", done, 0);
    chk("rst_busy", busy, 0);
    chk("rst_ready", cmd_ready, 1);

    // Vector table: command from IDLE, resulting state and first-step latency
    for (int v = 0; v < 8; v++) begin
      do_reset();
      send(vecs[v].op, vecs[v].speed);
      chk($sformatf("vec%0d_state", v), state, vecs[v].exp_state);
      chk($sformatf("vec%0d_busy", v), busy, vecs[v].exp_state != 0);
      count_to_step(40, lat);
      chk($sformatf("vec%0d_lat", v), lat, vecs[v].exp_lat);
    end

    // SWEEP speed 1: 14 steps 8 apart, done right after the last, then silence
    do_reset();
    send(2'd2, 2'd1);
    n = 0; last = 0; bad = 0; dones = 0; done_at = 0; st_done = -1;
    for (int k = 1; k <= 160; k++) begin
      tick();
      if (step) begin
        if (k - last != 8) bad++;
        n++;
        last = k;
      end
      if (done) begin
        dones++;
        done_at = k;
        st_done = state;
      end
    end
    chk("sweep_steps", n, 14);
    chk("sweep_gaps", bad, 0);
    chk("sweep_last_step", last, 112);
    chk("sweep_done_cnt", dones, 1);
    chk("sweep_done_at", done_at, 113);
    chk("sweep_done_state", st_done, 0);

    // PAUSE 5 cycles into a 16-cycle period, hold, resume: 11 cycles to next step
    do_reset();
    send(2'd1, 2'd2);
    count_to_step(40, lat);
    chk("pause_first", lat, 16);
    for (int k = 0; k < 4; k++) tick();
    cmd_valid = 1'b1; cmd_op = 2'd3;
    tick();
    cmd_valid = 1'b0;
    chk("pause_state", state, 3);
    n = 0;
    for (int k = 0; k < 20; k++) begin
      tick();
      if (step) n++;
    end
    chk("pause_nostep", n, 0);
    send(2'd3, 2'd0);
    chk("resume_state", state, 1);
    count_to_step(40, lat);
    chk("resume_lat", lat, 11);

    // Command held through a step cycle is taken on the following edge
    do_reset();
    send(2'd1, 2'd0);
    count_to_step(10, lat);
    chk("hold_step_seen", lat, 4);
    cmd_valid = 1'b1; cmd_op = 2'd2; cmd_speed = 2'd0;
    chk("hold_ready_low", cmd_ready, 0);
    tick();
    chk("hold_not_taken", state, 1);
    chk("hold_ready_high", cmd_ready, 1);
    tick();
    cmd_valid = 1'b0;
    chk("hold_taken", state, 2);
    count_to_step(10, lat);
    chk("hold_lat", lat, 4);

`ifdef KR_CTRL_PARK_EN
    // STOP away from home: parks after walking back to pos 0 ascending
    do_reset();
    send(2'd1, 2'd0);
    tick(); tick();
    cmd_valid = 1'b1; cmd_op = 2'd0; ld_req = 1'b1; ld_pos = 3'd5; ld_dir = 1'b0;
    tick();
    cmd_valid = 1'b0; ld_req = 1'b0;
    chk("park_state", state, 4);
    chk("park_ready", cmd_ready, 0);
    n = 0;
    for (int k = 0; k < 200; k++) begin
      tick();
      if (step) n++;
      if (state == 3'd0) break;
    end
    chk("park_steps", n, 9);
    chk("park_idle", state, 0);
    n = 0;
    for (int k = 0; k < 20; k++) begin
      tick();
      if (step) n++;
    end
    chk("park_after", n, 0);

    // STOP while already home: IDLE on the next edge, no step
    do_reset();
    send(2'd1, 2'd0);
    tick();
    cmd_valid = 1'b1; cmd_op = 2'd0; ld_req = 1'b1; ld_pos = 3'd0; ld_dir = 1'b0;
    tick();
    cmd_valid = 1'b0; ld_req = 1'b0;
    chk("home_park", state, 4);
    chk("home_step0", step, 0);
    tick();
    chk("home_idle", state, 0);
    chk("home_step1", step, 0);
`else
    // STOP goes straight to IDLE
    do_reset();
    send(2'd1, 2'd0);
    tick();
    cmd_valid = 1'b1; cmd_op = 2'd0;
    tick();
    cmd_valid = 1'b0;
    chk("stop_idle", state, 0);
    chk("stop_busy", busy, 0);
    chk("stop_ready", cmd_ready, 1);
    n = 0;
    for (int k = 0; k < 20; k++) begin
      tick();
      if (step) n++;
    end
    chk("stop_nostep", n, 0);
`endif

    // Reset during the 7th sweep step: everything back to reset values, no done
    do_reset();
    send(2'd2, 2'd0);
    n = 0;
    for (int k = 0; k < 60 && n < 7; k++) begin
      tick();
      if (step) n++;
    end
    chk("mid_steps", n, 7);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("mid_state", state, 0);
    chk("mid_step", step, 0);
    chk("mid_done", done, 0);
    chk("mid_busy", busy, 0);
    chk("mid_ready", cmd_ready, 1);
    n = 0; dones = 0;
    for (int k = 0; k < 80; k++) begin
      tick();
      if (step) n++;
      if (done) dones++;
    end
    chk("mid_after_steps", n, 0);
    chk("mid_after_done", dones, 0);

    // Randomized run against the reference model
    for (int i = 0; i < 3000; i++) begin
      reset = (i == 0) || ($urandom_range(0, 299) == 0);
      if (!(cmd_valid && !m_ready())) begin
        cmd_valid = ($urandom_range(0, 2) == 0);
        cmd_op    = 2'($urandom_range(0, 3));
        cmd_speed = 2'($urandom_range(0, 1));
      end
      if (i > 0) chk("rnd_outputs", {state, busy, step, done, cmd_ready}, m_vec());
      @(posedge clk);
      model_edge();
      #1;
    end
    reset = 1'b0;
    cmd_valid = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
